load_store_unit: RTL and testbench

Initiator-side memory access unit placed between the single-cycle/multi-cycle core datapath and the word-addressed data memory. It accepts one load or store request at a time from the core and translates it into data-memory read/write strobes. It performs byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores, because the data memory is word-only. Results return to the core with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
// Sub-word support is controlled by the LSU_SUBWORD_EN macro.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Accept-edge to resp_valid cycle counts
  localparam int LAT_LOAD      = 2;
  localparam int LAT_STORE_W   = 2;
  localparam int LAT_STORE_SUB = 3;
  localparam int LAT_ERROR     = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

  // Width/alignment check only; store-specific legality is added by the caller
  function automatic logic req_is_bad(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b1;
`ifdef LSU_SUBWORD_EN
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = a[0];
      F3_W:        bad = (a != 2'b00);
      default:     bad = 1'b1;
    endcase
`else
    bad = (f3 != F3_W) || (a != 2'b00);
`endif
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
// With LSU_SUBWORD_EN undefined the block reduces to word pass-through.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ld_word,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] new_data,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    load_data  = ld_word;
    store_word = new_data;
    byte_lane  = ld_word[{addr_lo, 3'b000} +: 8];
    half_lane  = ld_word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_H:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_lane};
      default: ;
    endcase
    // Little-endian lane replacement over the word read back from memory
    case (funct3)
      F3_B: begin
        store_word = old_word;
        store_word[{addr_lo, 3'b000} +: 8] = new_data[7:0];
      end
      F3_H: begin
        store_word = old_word;
        store_word[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
      end
      default: ;
    endcase
  end
`else
  logic unused_lane_inputs;

  assign unused_lane_inputs = ^{old_word, addr_lo, funct3};
  assign load_data          = ld_word;
  assign store_word         = new_data;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-only data memory.
// LSU_SUBWORD_EN enables B/H/BU/HU accesses with read-modify-write stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_din,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_dout
);

  lsu_state_e      state_reg, state_next;
  logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [2:0]      funct3_reg;
  logic            error_reg;
  logic [XLEN-1:0] old_word, load_data, store_word;
  logic            accept, req_bad;

`ifdef LSU_SUBWORD_EN
  logic [XLEN-1:0] merge_reg;
  assign old_word = merge_reg;
`else
  assign old_word = '0;
`endif

  assign accept  = (state_reg == IDLE) && req_valid;
  // funct3 with bit 2 set is a load-only width
  assign req_bad = req_is_bad(req_funct3, req_addr[1:0]) || (req_write && req_funct3[2]);

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .ld_word    (mem_dout),
    .old_word   (old_word),
    .new_data   (wdata_reg),
    .addr_lo    (addr_reg[1:0]),
    .funct3     (funct3_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      funct3_reg <= '0;
      error_reg  <= 1'b0;
`ifdef LSU_SUBWORD_EN
      merge_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
        error_reg  <= req_bad;
        rdata_reg  <= '0;
      end
      if (state_reg == LOAD) rdata_reg <= load_data;
`ifdef LSU_SUBWORD_EN
      if (state_reg == RMW_RD) merge_reg <= mem_dout;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_din    = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                    state_next = RESP;
          else if (!req_write)            state_next = LOAD;
          else if (req_funct3 == F3_W)    state_next = STORE;
`ifdef LSU_SUBWORD_EN
          else                            state_next = RMW_RD;
`else
          else                            state_next = STORE;
`endif
        end
      end
      LOAD: begin
        mem_read   = 1'b1;
        state_next = RESP;
      end
      STORE: begin
        mem_write  = 1'b1;
        mem_din    = store_word;
        state_next = RESP;
      end
`ifdef LSU_SUBWORD_EN
      RMW_RD: begin
        mem_read   = 1'b1;
        state_next = RMW_WR;
      end
      RMW_WR: begin
        mem_write  = 1'b1;
        mem_din    = store_word;
        state_next = RESP;
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr   = (mem_read || mem_write) ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : '0;
  assign resp_error = resp_valid && error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model.
// Expectations follow LSU_SUBWORD_EN when it is defined for the build.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:31];

  int checks = 0;
  int failures = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_din;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request at the current negedge; masks mark cycles (bit k = cycle k after accept)
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [7:0] exp_rd_mask, input logic [7:0] exp_wr_mask,
                        input logic [31:0] exp_din);
    logic [7:0]  rd_mask, wr_mask;
    logic [31:0] rd_addr, wr_addr, din, rdata;
    logic        err, both;
    int          lat;
    rd_mask = '0; wr_mask = '0; rd_addr = '0; wr_addr = '0; din = '0;
    rdata = '0; err = 1'b0; both = 1'b0; lat = 0;
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (mem_read)  begin rd_mask[k] = 1'b1; rd_addr = mem_addr; end
      if (mem_write) begin wr_mask[k] = 1'b1; wr_addr = mem_addr; din = mem_din; end
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_error;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".error"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".rd_mask"}, {24'b0, rd_mask}, {24'b0, exp_rd_mask});
    check({tag, ".wr_mask"}, {24'b0, wr_mask}, {24'b0, exp_wr_mask});
    check({tag, ".rd_wr_overlap"}, {31'b0, both}, 32'd0);
    if (exp_rd_mask != 8'd0) check({tag, ".rd_addr"}, rd_addr, {addr[31:2], 2'b00});
    if (exp_wr_mask != 8'd0) begin
      check({tag, ".wr_addr"}, wr_addr, {addr[31:2], 2'b00});
      check({tag, ".mem_din"}, din, exp_din);
    end
    @(negedge clk);
    check({tag, ".idle_resp"}, {resp_valid, resp_error, resp_rdata[29:0]}, 32'd0);
    check({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
    $display("txn %s wr=%0b f3=%03b addr=0x%08h lat=%0d rdata=0x%08h err=%0b",
             tag, wr, f3, addr, lat, rdata, err);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, ".strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".mem_din"}, mem_din, 32'd0);
    check({tag, ".resp"}, {31'b0, resp_valid} | {31'b0, resp_error} | resp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc [2];
    int          n_acc, n_resp, ready_low;
    logic [31:0] resp_words [2];
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h80FF1234;
    mem[16] = 32'h01020304;

    repeat (2) @(negedge clk);
    check_quiet("reset_held");
    reset = 1'b1;
    @(negedge clk);
    check_quiet("reset_released");

    do_req("lw_0x10", 1'b0, F3_W, 32'h10, 32'h0, LAT_LOAD, 32'hDEADBEEF, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("sw_0x28", 1'b1, F3_W, 32'h28, 32'hCAFEF00D, LAT_STORE_W, 32'h0, 1'b0, 8'h00, 8'h02, 32'hCAFEF00D);
    check("sw_0x28.mem", mem[10], 32'hCAFEF00D);
    do_req("lw_0x28", 1'b0, F3_W, 32'h28, 32'h0, LAT_LOAD, 32'hCAFEF00D, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("lh_0x05", 1'b0, F3_H, 32'h05, 32'h0, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("sw_0x06", 1'b1, F3_W, 32'h06, 32'h12345678, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("lw_0x12", 1'b0, F3_W, 32'h12, 32'h0, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("st_f3_bu", 1'b1, F3_BU, 32'h20, 32'hFF, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);

`ifdef LSU_SUBWORD_EN
    do_req("lb_0x33", 1'b0, F3_B, 32'h33, 32'h0, LAT_LOAD, 32'hFFFFFF80, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("lbu_0x33", 1'b0, F3_BU, 32'h33, 32'h0, LAT_LOAD, 32'h00000080, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("lhu_0x32", 1'b0, F3_HU, 32'h32, 32'h0, LAT_LOAD, 32'h000080FF, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("lh_0x32", 1'b0, F3_H, 32'h32, 32'h0, LAT_LOAD, 32'hFFFF80FF, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("lbu_0x30", 1'b0, F3_BU, 32'h30, 32'h0, LAT_LOAD, 32'h00000034, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("sb_0x21", 1'b1, F3_B, 32'h21, 32'h000000AB, LAT_STORE_SUB, 32'h0, 1'b0, 8'h02, 8'h04, 32'h1122AB44);
    check("sb_0x21.mem", mem[8], 32'h1122AB44);
    do_req("sh_0x22", 1'b1, F3_H, 32'h22, 32'h12345678, LAT_STORE_SUB, 32'h0, 1'b0, 8'h02, 8'h04, 32'h5678AB44);
    check("sh_0x22.mem", mem[8], 32'h5678AB44);
`else
    do_req("lb_0x33", 1'b0, F3_B, 32'h33, 32'h0, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("lhu_0x32", 1'b0, F3_HU, 32'h32, 32'h0, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("sb_0x21", 1'b1, F3_B, 32'h21, 32'h000000AB, LAT_ERROR, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    check("sb_0x21.mem", mem[8], 32'h11223344);
`endif

    // Abort a store in its first busy cycle, before any write edge
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h5555BEEF;
`ifdef LSU_SUBWORD_EN
    req_funct3 = F3_H;
`else
    req_funct3 = F3_W;
`endif
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_SUBWORD_EN
    check("abort.busy_strobe", {30'b0, mem_read, mem_write}, 32'd2);
`else
    check("abort.busy_strobe", {30'b0, mem_read, mem_write}, 32'd1);
`endif
    reset = 1'b0;
    #1;
    check_quiet("abort.in_reset");
    @(negedge clk);
    reset = 1'b1;
    n_resp = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) n_resp++;
      @(negedge clk);
    end
    check("abort.no_resp", n_resp, 0);
    check("abort.mem_unchanged", mem[16], 32'h01020304);
    check_quiet("abort.after_release");
    $display("txn abort_store addr=0x00000040 mem=0x%08h resp_pulses=%0d", mem[16], n_resp);
    do_req("lw_0x40", 1'b0, F3_W, 32'h40, 32'h0, LAT_LOAD, 32'h01020304, 1'b0, 8'h02, 8'h00, 32'h0);

    // Two LWs with req_valid held high
    n_acc = 0; n_resp = 0; ready_low = 0;
    acc[0] = -1; acc[1] = -1;
    resp_words[0] = '0; resp_words[1] = '0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      if (req_ready && req_valid) begin
        if (n_acc < 2) acc[n_acc] = c;
        n_acc++;
      end else if (n_acc == 2) begin
        req_valid = 1'b0;
      end
      if (!req_ready && n_acc == 1) ready_low++;
      if (resp_valid) begin
        if (n_resp < 2) resp_words[n_resp] = resp_rdata;
        n_resp++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b.accepts", n_acc, 2);
    check("b2b.first_accept", acc[0], 0);
    check("b2b.second_accept", acc[1], 3);
    check("b2b.ready_low", ready_low, 2);
    check("b2b.resp_count", n_resp, 2);
    check("b2b.rdata0", resp_words[0], 32'hDEADBEEF);
    check("b2b.rdata1", resp_words[1], 32'hDEADBEEF);
    $display("txn b2b_lw accepts=%0d at %0d,%0d responses=%0d", n_acc, acc[0], acc[1], n_resp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
